// File: rtl/json_cmd_serializer.sv
// json_cmd_serializer: formats a drive command (motion type plus signed
// left/right wheel speeds) into a fixed-width ASCII JSON frame
//   {"T":t,"L":sd.dd,"R":sd.dd}
// and streams it byte by byte to the UART over valid/ready. A one-deep
// pending slot lets the next command queue up while a frame is on the wire.
// Optional build macro: JSON_NEWLINE_EN appends 8'h0A, giving a 28-byte frame.
module json_cmd_serializer #(
  parameter int SPEED_W   = 12,
  parameter int SPEED_MAX = 999
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                cmd_type,
  input  logic signed [SPEED_W-1:0] left_speed,
  input  logic signed [SPEED_W-1:0] right_speed,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      clamped,
  output logic [15:0]               frames_sent
);

`ifdef JSON_NEWLINE_EN
  localparam int FRAME_LEN = 28;
`else
  localparam int FRAME_LEN = 27;
`endif
  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                    state;
  logic [4:0]                idx;
  logic                      pend_full;
  logic                      pend_clamp;
  logic [3:0]                pend_type;
  logic signed [SPEED_W-1:0] pend_left;
  logic signed [SPEED_W-1:0] pend_right;
  logic [7:0]                frame      [FRAME_LEN];
  logic [7:0]                frame_next [FRAME_LEN];
  logic                      accept;
  logic                      clamp_in;
  logic [3:0]                type_sat;
  logic [39:0]               left_field;
  logic [39:0]               right_field;

  // Magnitude in one extra bit so the most negative input cannot overflow.
  function automatic logic [SPEED_W:0] speed_mag(input logic signed [SPEED_W-1:0] v);
    logic [SPEED_W:0] ext;
    ext = {v[SPEED_W-1], v};
    return v[SPEED_W-1] ? (~ext + (SPEED_W+1)'(1'b1)) : ext;
  endfunction

  function automatic logic speed_sat(input logic signed [SPEED_W-1:0] v);
    return speed_mag(v) > (SPEED_W+1)'(SPEED_MAX);
  endfunction

  // Five ASCII chars: sign ('-' or '0'), integer digit, '.', tenths, hundredths.
  function automatic logic [39:0] speed_field(input logic signed [SPEED_W-1:0] v);
    logic [9:0] val;
    logic [3:0] d_h;
    logic [3:0] d_t;
    logic [3:0] d_o;
    logic [7:0] sign;
    val  = speed_sat(v) ? 10'(SPEED_MAX) : 10'(speed_mag(v));
    d_h  = 4'(val / 10'd100);
    d_t  = 4'((val % 10'd100) / 10'd10);
    d_o  = 4'(val % 10'd10);
    // A zero magnitude never carries a minus sign.
    sign = (v[SPEED_W-1] && (val != 10'd0)) ? 8'h2D : 8'h30;
    return {sign, 8'h30 + {4'h0, d_h}, 8'h2E, 8'h30 + {4'h0, d_t}, 8'h30 + {4'h0, d_o}};
  endfunction

  assign cmd_ready   = !pend_full;
  assign accept      = cmd_valid && !pend_full;
  assign clamp_in    = (cmd_type > 4'd9) || speed_sat(left_speed) || speed_sat(right_speed);
  assign type_sat    = (pend_type > 4'd9) ? 4'd9 : pend_type;
  assign left_field  = speed_field(pend_left);
  assign right_field = speed_field(pend_right);

  // Build the complete frame image from the pending command.
  always_comb begin
    for (int i = 0; i < FRAME_LEN; i++) frame_next[i] = 8'h00;
    frame_next[0]  = 8'h7B;  // {
    frame_next[1]  = 8'h22;  // "
    frame_next[2]  = 8'h54;  // T
    frame_next[3]  = 8'h22;
    frame_next[4]  = 8'h3A;  // :
    frame_next[5]  = 8'h30 + {4'h0, type_sat};
    frame_next[6]  = 8'h2C;  // ,
    frame_next[7]  = 8'h22;
    frame_next[8]  = 8'h4C;  // L
    frame_next[9]  = 8'h22;
    frame_next[10] = 8'h3A;
    frame_next[11] = left_field[39:32];
    frame_next[12] = left_field[31:24];
    frame_next[13] = left_field[23:16];
    frame_next[14] = left_field[15:8];
    frame_next[15] = left_field[7:0];
    frame_next[16] = 8'h2C;
    frame_next[17] = 8'h22;
    frame_next[18] = 8'h52;  // R
    frame_next[19] = 8'h22;
    frame_next[20] = 8'h3A;
    frame_next[21] = right_field[39:32];
    frame_next[22] = right_field[31:24];
    frame_next[23] = right_field[23:16];
    frame_next[24] = right_field[15:8];
    frame_next[25] = right_field[7:0];
    frame_next[26] = 8'h7D;  // }
`ifdef JSON_NEWLINE_EN
    frame_next[27] = 8'h0A;
`endif
  end

  // Pending slot: latch on accept, free when LOAD consumes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_full  <= 1'b0;
      pend_clamp <= 1'b0;
      pend_type  <= 4'd0;
      pend_left  <= '0;
      pend_right <= '0;
    end else if (accept) begin
      pend_full  <= 1'b1;
      pend_clamp <= clamp_in;
      pend_type  <= cmd_type;
      pend_left  <= left_speed;
      pend_right <= right_speed;
    end else if (state == LOAD) begin
      pend_full  <= 1'b0;
    end
  end

  // Frame FSM with registered byte stream, status and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 5'd0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      clamped     <= 1'b0;
      frames_sent <= 16'd0;
    end else begin
      clamped <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_full) begin
            state   <= LOAD;
            busy    <= 1'b1;
            clamped <= pend_clamp;
          end else begin
            busy    <= 1'b0;
          end
        end
        LOAD: begin
          for (int i = 0; i < FRAME_LEN; i++) frame[i] <= frame_next[i];
          tx_data  <= frame_next[0];
          tx_valid <= 1'b1;
          idx      <= 5'd0;
          busy     <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              frames_sent <= frames_sent + 16'd1;
              tx_valid    <= 1'b0;
              tx_data     <= 8'h00;
              idx         <= 5'd0;
              // A command arriving on the final handshake still goes straight to LOAD.
              if (pend_full || accept) begin
                state   <= LOAD;
                busy    <= 1'b1;
                clamped <= pend_full ? pend_clamp : clamp_in;
              end else begin
                state   <= IDLE;
                busy    <= 1'b0;
              end
            end else begin
              idx     <= idx + 5'd1;
              tx_data <= frame[idx + 5'd1];
            end
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
